// File: rtl/axi_addr_admit.sv
// AXI address-channel admission: region decode plus per-ID thread tracking with
// global and per-master outstanding limits; completions retire transactions by ID.
module axi_addr_admit #(
    parameter int M_COUNT = 4,
    parameter int M_REGIONS = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH = 8,
    parameter int THREADS = 4,
    parameter int ACCEPT = 16,
    parameter logic [M_COUNT*32-1:0] M_ISSUE = {M_COUNT{32'd8}},
    parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT*M_REGIONS{32'd24}},
    parameter logic [M_COUNT-1:0] M_SECURE = '0,
    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
    localparam int CNT_W = $clog2(ACCEPT + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   s_aid,
    input  logic [ADDR_WIDTH-1:0] s_aaddr,
    input  logic [2:0]            s_aprot,
    input  logic                  s_avalid,
    output logic                  s_aready,
    output logic [SEL_W-1:0]      m_select,
    output logic [3:0]            m_aregion,
    output logic                  m_decerr,
    output logic                  m_avalid,
    input  logic                  m_aready,
    input  logic [ID_WIDTH-1:0]   s_cpl_id,
    input  logic                  s_cpl_valid,
    output logic                  cpl_err,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  fsm_state
);

    localparam int NR = M_COUNT * M_REGIONS;
    localparam int TH = (THREADS < ACCEPT) ? THREADS : ACCEPT;
    localparam int TH_W = (TH > 1) ? $clog2(TH) : 1;

    // Packed contiguous allocation: each enabled region is aligned to its own size.
    function automatic logic [NR*ADDR_WIDTH-1:0] calc_base();
        logic [NR*ADDR_WIDTH-1:0] addrs;
        logic [63:0] base;
        logic [63:0] mask;
        int w;
        addrs = '0;
        base = '0;
        for (int i = 0; i < NR; i++) begin
            w = int'(M_ADDR_WIDTH[i*32 +: 32]);
            mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
            if (w > 0) begin
                if ((base & mask) != 64'd0) base = base + (mask + 64'd1) - (base & mask);
                addrs[i*ADDR_WIDTH +: ADDR_WIDTH] = base[ADDR_WIDTH-1:0];
                base = base + mask + 64'd1;
            end
        end
        return addrs;
    endfunction

    function automatic int max_issue();
        int m;
        m = 1;
        for (int j = 0; j < M_COUNT; j++)
            if (int'(M_ISSUE[j*32 +: 32]) > m) m = int'(M_ISSUE[j*32 +: 32]);
        return m;
    endfunction

    localparam logic [NR*ADDR_WIDTH-1:0] BASE = (M_BASE_ADDR == '0) ? calc_base() : M_BASE_ADDR;
    localparam int MC_W = $clog2(max_issue() + 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t state_q, state_d;
    logic   rst_done;

    logic [ID_WIDTH-1:0] thr_id  [TH];
    logic [SEL_W-1:0]    thr_m   [TH];
    logic [3:0]          thr_r   [TH];
    logic [CNT_W-1:0]    thr_cnt [TH];
    logic [CNT_W-1:0]    count;
    logic [MC_W-1:0]     m_cnt   [M_COUNT];

    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic [3:0]       dec_reg;
    logic             cpl_hit;
    logic [TH_W-1:0]  cpl_idx;
    logic [SEL_W-1:0] cpl_m;
    logic             same_found, free_found, thr_ok, glob_ok, mst_ok;
    logic [TH_W-1:0]  same_idx, free_idx, alloc_idx;
    logic             decode_en, admit, miss;
    logic [TH-1:0]      thr_inc, thr_dec;
    logic [M_COUNT-1:0] mst_inc, mst_dec;

    logic             aready_d, avalid_d, decerr_d;
    logic [SEL_W-1:0] select_d;
    logic [3:0]       region_d;

    logic unused_prot;
    assign unused_prot = s_aprot[2] ^ s_aprot[0];

    // Region decode; later (higher-index) hits override earlier ones.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        dec_reg = '0;
        for (int i = 0; i < NR; i++) begin
            if ((M_ADDR_WIDTH[i*32 +: 32] != 32'd0) &&
                !(M_SECURE[i / M_REGIONS] && s_aprot[1]) &&
                ((s_aaddr >> M_ADDR_WIDTH[i*32 +: 32]) ==
                 (BASE[i*ADDR_WIDTH +: ADDR_WIDTH] >> M_ADDR_WIDTH[i*32 +: 32]))) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i / M_REGIONS);
                dec_reg = 4'(i % M_REGIONS);
            end
        end
    end

    // A slot is active exactly while its count is non-zero.
    always_comb begin
        cpl_hit = 1'b0;
        cpl_idx = '0;
        same_found = 1'b0;
        same_idx = '0;
        free_found = 1'b0;
        free_idx = '0;
        for (int i = 0; i < TH; i++) begin
            if (s_cpl_valid && thr_cnt[i] != '0 && thr_id[i] == s_cpl_id) begin
                cpl_hit = 1'b1;
                cpl_idx = TH_W'(i);
            end
            if (thr_cnt[i] != '0 && thr_id[i] == s_aid) begin
                same_found = 1'b1;
                same_idx = TH_W'(i);
            end
        end
        for (int i = TH - 1; i >= 0; i--) begin
            if (thr_cnt[i] == '0) begin
                free_found = 1'b1;
                free_idx = TH_W'(i);
            end
        end
    end

    assign cpl_m = thr_m[cpl_idx];
    assign thr_ok = same_found ? (thr_m[same_idx] == dec_sel && thr_r[same_idx] == dec_reg)
                               : free_found;
    assign alloc_idx = same_found ? same_idx : free_idx;
    assign glob_ok = (int'(count) < ACCEPT) || cpl_hit;

    always_comb begin
        mst_ok = 1'b0;
        for (int j = 0; j < M_COUNT; j++)
            if (dec_sel == SEL_W'(j))
                mst_ok = (int'(m_cnt[j]) < int'(M_ISSUE[j*32 +: 32])) ||
                         (cpl_hit && cpl_m == SEL_W'(j));
    end

    assign decode_en = (state_q == IDLE) && s_avalid && rst_done;
    assign admit = decode_en && dec_hit && glob_ok && mst_ok && thr_ok;
    assign miss = decode_en && !dec_hit;

    always_comb begin
        thr_inc = '0;
        thr_dec = '0;
        mst_inc = '0;
        mst_dec = '0;
        for (int i = 0; i < TH; i++) begin
            thr_inc[i] = admit && alloc_idx == TH_W'(i);
            thr_dec[i] = cpl_hit && cpl_idx == TH_W'(i);
        end
        for (int j = 0; j < M_COUNT; j++) begin
            mst_inc[j] = admit && dec_sel == SEL_W'(j);
            mst_dec[j] = cpl_hit && cpl_m == SEL_W'(j);
        end
    end

    // Handshake: s_aready pulses one cycle after the decode cycle and the upstream
    // request is consumed then; m_avalid holds with stable routing until m_aready.
    always_comb begin
        state_d = state_q;
        aready_d = 1'b0;
        avalid_d = m_avalid;
        decerr_d = m_decerr;
        select_d = m_select;
        region_d = m_aregion;
        case (state_q)
            IDLE: begin
                if (admit || miss) begin
                    state_d = ISSUE;
                    aready_d = 1'b1;
                    avalid_d = 1'b1;
                    decerr_d = miss;
                    select_d = miss ? '0 : dec_sel;
                    region_d = miss ? '0 : dec_reg;
                end
            end
            ISSUE: begin
                if (m_aready) begin
                    state_d = IDLE;
                    avalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rst_done  <= 1'b0;
            s_aready  <= 1'b0;
            m_avalid  <= 1'b0;
            m_decerr  <= 1'b0;
            m_select  <= '0;
            m_aregion <= '0;
        end else begin
            state_q   <= state_d;
            rst_done  <= 1'b1;
            s_aready  <= aready_d;
            m_avalid  <= avalid_d;
            m_decerr  <= decerr_d;
            m_select  <= select_d;
            m_aregion <= region_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count   <= '0;
            cpl_err <= 1'b0;
            for (int i = 0; i < TH; i++) begin
                thr_cnt[i] <= '0;
                thr_id[i]  <= '0;
                thr_m[i]   <= '0;
                thr_r[i]   <= '0;
            end
            for (int j = 0; j < M_COUNT; j++) m_cnt[j] <= '0;
        end else begin
            cpl_err <= s_cpl_valid && !cpl_hit;
            if (admit && !cpl_hit) count <= count + CNT_W'(1);
            else if (!admit && cpl_hit) count <= count - CNT_W'(1);
            for (int i = 0; i < TH; i++) begin
                if (thr_inc[i] && !thr_dec[i]) thr_cnt[i] <= thr_cnt[i] + CNT_W'(1);
                else if (!thr_inc[i] && thr_dec[i]) thr_cnt[i] <= thr_cnt[i] - CNT_W'(1);
                if (thr_inc[i]) begin
                    thr_id[i] <= s_aid;
                    thr_m[i]  <= dec_sel;
                    thr_r[i]  <= dec_reg;
                end
            end
            for (int j = 0; j < M_COUNT; j++) begin
                if (mst_inc[j] && !mst_dec[j]) m_cnt[j] <= m_cnt[j] + MC_W'(1);
                else if (!mst_inc[j] && mst_dec[j]) m_cnt[j] <= m_cnt[j] - MC_W'(1);
            end
        end
    end

    assign outstanding = count;
    assign fsm_state = state_q;

endmodule
